// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-level constants and types for the CPU OBI arbiter.
//   arb_state_e           : arbitration FSM states
//   MAX_OUTSTANDING_LIMIT : upper bound on the outstanding-transaction depth
//   clamp_outstanding()   : maps a requested depth into the legal 1..LIMIT range
package core_v_mini_mcu_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,  // no request being held on the bus
    ARB_LOCKED = 1'b1   // request issued, waiting for gnt
  } arb_state_e;

  localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;

  function automatic int unsigned clamp_outstanding(input int unsigned n);
    if (n < 1) return 1;
    if (n > MAX_OUTSTANDING_LIMIT) return MAX_OUTSTANDING_LIMIT;
    return n;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// Shared OBI bus types used by the CPU-side arbiter and its clients.
//   obi_req_t  : request channel (req, we, be, addr, wdata)
//   obi_resp_t : response channel (gnt, rvalid, rdata)
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_owner_fifo.sv
// In-order tracker of which requester owns each outstanding bus transaction.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : record a granted transaction, owner push_id_i
//   pop_i        : retire the oldest transaction (ignored when empty)
//   head_id_o    : owner of the oldest outstanding transaction
//   full_o       : DEPTH entries outstanding
//   empty_o      : nothing outstanding
module obi_owner_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic head_id_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_i & (~full_o | do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign mem_d[gi] = (do_push && (wr_ptr_q == PTR_W'(gi))) ? push_id_i : mem_q[gi];
    end
  endgenerate

  always_comb begin
    head_id_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rd_ptr_q == PTR_W'(i)) head_id_o = mem_q[i];
    end
  end

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cpu_obi_arbiter.sv
// Two-to-one OBI arbiter merging the CPU data port (requester 0) and
// instruction port (requester 1) onto a single memory bus.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   data_req_i/_resp_o  : requester 0 channel
//   instr_req_i/_resp_o : requester 1 channel
//   bus_req_o/bus_resp_i: merged memory-side channel
//   protocol_err_o    : sticky, set by an rvalid with nothing outstanding
// Request and response paths are purely combinational; only the arbitration
// state, round-robin pointer, owner FIFO and error flag are registered.
module cpu_obi_arbiter
  import obi_pkg::*;
  import core_v_mini_mcu_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING   = 2,
  parameter logic        DATA_HAS_PRIORITY = 1'b0
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  data_req_i,
  output obi_resp_t data_resp_o,
  input  obi_req_t  instr_req_i,
  output obi_resp_t instr_resp_o,
  output obi_req_t  bus_req_o,
  input  obi_resp_t bus_resp_i,
  output logic      protocol_err_o
);

  localparam int unsigned FIFO_DEPTH = clamp_outstanding(MAX_OUTSTANDING);

  arb_state_e state_q;
  logic       sel_q;    // requester held while LOCKED
  logic       prio_q;   // requester favoured on a tie (the one not granted last)
  logic       err_q;

  logic       sel;
  obi_req_t   sel_req;
  logic       blocked;
  logic       issue;
  logic       push;
  logic       pop;
  logic       stray_rvalid;
  logic       fifo_full;
  logic       fifo_empty;
  logic       head_id;

  always_comb begin
    if (state_q == ARB_LOCKED) begin
      sel = sel_q;
    end else if (data_req_i.req && instr_req_i.req) begin
      sel = DATA_HAS_PRIORITY ? 1'b0 : prio_q;
    end else begin
      sel = instr_req_i.req;
    end

    sel_req = sel ? instr_req_i : data_req_i;

    // A returning rvalid pops the FIFO this cycle, so a full tracker can
    // still accept a new grant alongside it.
    blocked = fifo_full & ~bus_resp_i.rvalid;
    issue   = sel_req.req & ~blocked & ~rst_i;
    push    = issue & bus_resp_i.gnt;
    pop     = bus_resp_i.rvalid & ~fifo_empty & ~rst_i;
    stray_rvalid = bus_resp_i.rvalid & fifo_empty;

    bus_req_o     = sel_req;
    bus_req_o.req = issue;

    data_resp_o         = '0;
    instr_resp_o        = '0;
    data_resp_o.gnt     = push & ~sel;
    instr_resp_o.gnt    = push & sel;
    data_resp_o.rvalid  = pop & ~head_id;
    instr_resp_o.rvalid = pop & head_id;
    data_resp_o.rdata   = (pop && !head_id) ? bus_resp_i.rdata : '0;
    instr_resp_o.rdata  = (pop && head_id) ? bus_resp_i.rdata : '0;
  end

  assign protocol_err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_q | stray_rvalid;
      if (push) begin
        state_q <= ARB_IDLE;
        prio_q  <= ~sel;
      end else if (issue) begin
        state_q <= ARB_LOCKED;
        sel_q   <= sel;
      end else if (state_q == ARB_LOCKED && !sel_req.req) begin
        // Requester withdrew; release the lock rather than wedge the bus.
        state_q <= ARB_IDLE;
      end
    end
  end

  obi_owner_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_owner_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push),
    .push_id_i(sel),
    .pop_i    (pop),
    .head_id_o(head_id),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

endmodule

// File: tb/tb_cpu_obi_arbiter.sv
module tb_cpu_obi_arbiter;
  import obi_pkg::*;

  localparam logic [31:0] DA = 32'h0000_0100;
  localparam logic [31:0] IA = 32'h0000_0180;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      rst;
  obi_req_t  dreq, ireq;
  obi_resp_t bresp;
  obi_req_t  a_breq, b_breq;
  obi_resp_t a_dresp, a_iresp, b_dresp, b_iresp;
  logic      a_err, b_err;

  cpu_obi_arbiter #(.MAX_OUTSTANDING(2), .DATA_HAS_PRIORITY(1'b0)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(dreq), .data_resp_o(a_dresp),
    .instr_req_i(ireq), .instr_resp_o(a_iresp),
    .bus_req_o(a_breq), .bus_resp_i(bresp),
    .protocol_err_o(a_err)
  );

  cpu_obi_arbiter #(.MAX_OUTSTANDING(2), .DATA_HAS_PRIORITY(1'b1)) u_fx (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(dreq), .data_resp_o(b_dresp),
    .instr_req_i(ireq), .instr_resp_o(b_iresp),
    .bus_req_o(b_breq), .bus_resp_i(bresp),
    .protocol_err_o(b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dr, input logic ir, input logic g, input logic rv,
                       input logic [31:0] rd);
    dreq        = '0;
    dreq.req    = dr;
    dreq.addr   = DA;
    dreq.be     = 4'hF;
    dreq.wdata  = 32'h5A5A_0100;
    ireq        = '0;
    ireq.req    = ir;
    ireq.addr   = IA;
    ireq.be     = 4'hF;
    bresp.gnt    = g;
    bresp.rvalid = rv;
    bresp.rdata  = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
  endtask

  // Outputs that must be quiet while reset is asserted.
  task automatic chk_quiet(input string tag);
    chk({tag, ".a_req"}, 32'(a_breq.req), 32'h0);
    chk({tag, ".a_gnt"}, 32'({a_dresp.gnt, a_iresp.gnt}), 32'h0);
    chk({tag, ".a_rv"},  32'({a_dresp.rvalid, a_iresp.rvalid}), 32'h0);
    chk({tag, ".b_req"}, 32'(b_breq.req), 32'h0);
    chk({tag, ".b_gnt"}, 32'({b_dresp.gnt, b_iresp.gnt}), 32'h0);
    chk({tag, ".b_rv"},  32'({b_dresp.rvalid, b_iresp.rvalid}), 32'h0);
  endtask

  typedef struct {
    logic        dr, ir, g, rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dg, e_ig, e_drv, e_irv;
    logic [31:0] e_drd, e_ird;
    logic        e_err;
  } vec_t;

  vec_t tbl[18];

  // Randomized run against a queue-based model of the arbiter rules.
  task automatic rand_phase(input bit fx, input int ncyc);
    bit       q[$];
    bit       last_gnt;
    int       pending;
    bit       m_err, hold_d, hold_i;
    obi_req_t rdq, riq, exp_bus, got_bus;
    obi_resp_t got_d, got_i;
    logic     g, rv;
    logic [31:0] rdat;
    int       sel;
    bit       room, e_req, e_gnt, e_pop, e_own;
    logic     got_err;

    do_reset();
    last_gnt = 1'b1;   // after reset the data port is favoured
    pending  = -1;
    m_err    = 1'b0;
    hold_d   = 1'b0;
    hold_i   = 1'b0;
    rdq      = '0;
    riq      = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (!hold_d && $urandom_range(0, 9) < 6) begin
        hold_d    = 1'b1;
        rdq.addr  = $urandom & 32'hFFFF_FFFC;
        rdq.we    = 1'($urandom_range(0, 1));
        rdq.be    = 4'($urandom_range(0, 15));
        rdq.wdata = $urandom;
      end
      if (!hold_i && $urandom_range(0, 9) < 6) begin
        hold_i    = 1'b1;
        riq.addr  = $urandom & 32'hFFFF_FFFC;
        riq.we    = 1'b0;
        riq.be    = 4'hF;
        riq.wdata = 32'h0;
      end
      rdq.req = hold_d;
      riq.req = hold_i;
      g    = 1'($urandom_range(0, 1));
      rv   = (q.size() > 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 29) == 0);
      rdat = $urandom;
      dreq = rdq;
      ireq = riq;
      bresp.gnt    = g;
      bresp.rvalid = rv;
      bresp.rdata  = rdat;
      #2;

      sel = -1;
      if (pending >= 0)          sel = pending;
      else if (hold_d && hold_i) sel = fx ? 0 : (last_gnt ? 0 : 1);
      else if (hold_d)           sel = 0;
      else if (hold_i)           sel = 1;
      e_pop = rv && (q.size() > 0);
      room  = (q.size() < DEPTH) || e_pop;
      e_req = (sel >= 0) && room;
      e_gnt = e_req && g;
      e_own = (q.size() > 0) ? q[0] : 1'b0;
      exp_bus = (sel == 1) ? riq : rdq;

      got_bus = fx ? b_breq : a_breq;
      got_d   = fx ? b_dresp : a_dresp;
      got_i   = fx ? b_iresp : a_iresp;
      got_err = fx ? b_err : a_err;

      chk($sformatf("rand%0d[%0d].req", fx, c), 32'(got_bus.req), 32'(e_req));
      if (e_req) begin
        chk($sformatf("rand%0d[%0d].addr", fx, c), got_bus.addr, exp_bus.addr);
        chk($sformatf("rand%0d[%0d].wdata", fx, c), got_bus.wdata, exp_bus.wdata);
        chk($sformatf("rand%0d[%0d].we_be", fx, c), 32'({got_bus.we, got_bus.be}),
            32'({exp_bus.we, exp_bus.be}));
      end
      chk($sformatf("rand%0d[%0d].gnt", fx, c), 32'({got_d.gnt, got_i.gnt}),
          32'({e_gnt && sel == 0, e_gnt && sel == 1}));
      chk($sformatf("rand%0d[%0d].rvalid", fx, c), 32'({got_d.rvalid, got_i.rvalid}),
          32'({e_pop && !e_own, e_pop && e_own}));
      chk($sformatf("rand%0d[%0d].drdata", fx, c), got_d.rdata, (e_pop && !e_own) ? rdat : 32'h0);
      chk($sformatf("rand%0d[%0d].irdata", fx, c), got_i.rdata, (e_pop && e_own) ? rdat : 32'h0);
      chk($sformatf("rand%0d[%0d].err", fx, c), 32'(got_err), 32'(m_err));

      if (rv) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1'b1;
      end
      if (e_gnt) begin
        q.push_back(sel[0]);
        last_gnt = sel[0];
        pending  = -1;
        if (sel == 0) hold_d = 1'b0;
        else          hold_i = 1'b0;
        $display("rand%0d cycle %0d: grant to %s addr=%h outstanding=%0d",
                 fx, c, (sel == 0) ? "data" : "instr", exp_bus.addr, q.size());
      end else if (e_req) begin
        pending = sel;
      end
      tick();
    end
  endtask

  initial begin
    // rows: dr ir g rv rd | e_req e_addr e_dg e_ig e_drv e_irv e_drd e_ird e_err
    // Alternating grants with data returned one cycle later.
    tbl[0]  = '{1'b1,1'b1,1'b1,1'b0,32'h00, 1'b1,DA,   1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b1,1'b1,32'hA0, 1'b1,IA,   1'b0,1'b1,1'b1,1'b0,32'hA0,32'h00,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b1,32'hA1, 1'b1,DA,   1'b1,1'b0,1'b0,1'b1,32'h00,32'hA1,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b1,1'b1,32'hA2, 1'b1,IA,   1'b0,1'b1,1'b1,1'b0,32'hA2,32'h00,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,32'hA3, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b1,32'h00,32'hA3,1'b0};
    // Instr request held with gnt low; data joins but the lock holds.
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h00, 1'b1,IA,   1'b0,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,32'h00, 1'b1,IA,   1'b0,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,32'h00, 1'b1,IA,   1'b0,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,32'h00, 1'b1,IA,   1'b0,1'b1,1'b0,1'b0,32'h00,32'h00,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,32'h00, 1'b1,DA,   1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0};
    // Two outstanding: blocked, then released by an rvalid in the same cycle.
    tbl[10] = '{1'b1,1'b1,1'b1,1'b0,32'h00, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0};
    tbl[11] = '{1'b1,1'b1,1'b1,1'b1,32'h55, 1'b1,IA,   1'b0,1'b1,1'b0,1'b1,32'h00,32'h55,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1,32'h66, 1'b0,32'h0,1'b0,1'b0,1'b1,1'b0,32'h66,32'h00,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b1,32'h77, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b1,32'h00,32'h77,1'b0};
    // Stray rvalid with nothing outstanding: dropped, error sticks.
    tbl[14] = '{1'b0,1'b0,1'b0,1'b1,32'h88, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h00,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,32'h00, 1'b0,32'h0,1'b0,1'b0,1'b0,1'b0,32'h00,32'h00,1'b1};
    tbl[16] = '{1'b1,1'b0,1'b1,1'b0,32'h00, 1'b1,DA,   1'b1,1'b0,1'b0,1'b0,32'h00,32'h00,1'b1};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b1,32'h99, 1'b0,32'h0,1'b0,1'b0,1'b1,1'b0,32'h99,32'h00,1'b1};

    // Reset with active inputs: outputs must stay quiet.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h11);
    #2;
    chk_quiet("rst0");
    tick();
    chk_quiet("rst1");
    chk("rst1.a_err", 32'(a_err), 32'h0);
    chk("rst1.b_err", 32'(b_err), 32'h0);
    tick();
    rst = 1'b0;

    // Table-driven sequence on the round-robin instance.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].dr, tbl[i].ir, tbl[i].g, tbl[i].rv, tbl[i].rd);
      #2;
      $display("vec %0d: dr=%0b ir=%0b gnt=%0b rvalid=%0b rdata=%h", i,
               tbl[i].dr, tbl[i].ir, tbl[i].g, tbl[i].rv, tbl[i].rd);
      chk($sformatf("v%0d.req", i), 32'(a_breq.req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("v%0d.addr", i), a_breq.addr, tbl[i].e_addr);
      chk($sformatf("v%0d.dgnt", i), 32'(a_dresp.gnt), 32'(tbl[i].e_dg));
      chk($sformatf("v%0d.ignt", i), 32'(a_iresp.gnt), 32'(tbl[i].e_ig));
      chk($sformatf("v%0d.drv", i), 32'(a_dresp.rvalid), 32'(tbl[i].e_drv));
      chk($sformatf("v%0d.irv", i), 32'(a_iresp.rvalid), 32'(tbl[i].e_irv));
      chk($sformatf("v%0d.drdata", i), a_dresp.rdata, tbl[i].e_drd);
      chk($sformatf("v%0d.irdata", i), a_iresp.rdata, tbl[i].e_ird);
      chk($sformatf("v%0d.err", i), 32'(a_err), 32'(tbl[i].e_err));
      tick();
    end

    // Reset with two outstanding; stale rvalid afterwards is a protocol error.
    do_reset();
    chk("rs.err_cleared", 32'(a_err), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    chk("rs.g0", 32'({a_dresp.gnt, a_iresp.gnt}), 32'b10);
    $display("seq reset: grant data");
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    chk("rs.g1", 32'({a_dresp.gnt, a_iresp.gnt}), 32'b01);
    $display("seq reset: grant instr, two outstanding");
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hBB);
    #2;
    chk_quiet("rs.during0");
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hBB);
    #2;
    chk_quiet("rs.during1");
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hCC);
    #2;
    chk("rs.stale_rv", 32'({a_dresp.rvalid, a_iresp.rvalid}), 32'h0);
    chk("rs.err_before", 32'(a_err), 32'h0);
    $display("seq reset: stale rvalid after reset");
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    chk("rs.err_after", 32'(a_err), 32'h1);
    chk("rs.first_arb_req", 32'(a_breq.req), 32'h1);
    chk("rs.first_arb_addr", a_breq.addr, DA);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    chk("rs.first_gnt", 32'({a_dresp.gnt, a_iresp.gnt}), 32'b10);
    chk("rs.err_sticky", 32'(a_err), 32'h1);
    $display("seq reset: first grant to data");
    tick();

    // Fixed-priority instance: data wins every tie.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b1, (k > 0), 32'hC0 + 32'(k));
      #2;
      chk($sformatf("fx%0d.gnt", k), 32'({b_dresp.gnt, b_iresp.gnt}), 32'b10);
      chk($sformatf("fx%0d.drv", k), 32'(b_dresp.rvalid), 32'(k > 0));
      if (k > 0) chk($sformatf("fx%0d.drdata", k), b_dresp.rdata, 32'hC0 + 32'(k));
      $display("seq fixed: cycle %0d both requesting", k);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hC4);
    #2;
    chk("fx4.gnt", 32'({b_dresp.gnt, b_iresp.gnt}), 32'b01);
    chk("fx4.drdata", b_dresp.rdata, 32'hC4);
    $display("seq fixed: instr alone");
    tick();

    rand_phase(1'b0, 400);
    rand_phase(1'b1, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
